// File: rtl/uart_pkg.sv
//============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding and line levels for tx and rx.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package uart_pkg;

  // Frame sequencer states, common to the transmitter and the receiver
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Line level while idle and during stop bits
  localparam logic UART_IDLE_LEVEL = 1'b1;
  // Line level of the start bit
  localparam logic START_LEVEL     = 1'b0;

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
//============================================================================
// Module      : uart_tx_if
// Description : Byte write handshake between a writer and the UART tx FIFO.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface uart_tx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  // Writer side
  modport master (output tx_data, output tx_valid, input tx_ready);
  // Transmitter side
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
//============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous first-word-fall-through FIFO with wrap-bit
//               pointers. A push while full is taken only alongside a pop.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer lapped the reader
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset discards any stored bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
//============================================================================
// Module      : uart_tx
// Description : UART transmitter. Buffers bytes in a small FIFO and frames
//               them LSB first as start/data/[parity]/stop, one bit per
//               baud strobe, on a registered idle-high line.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic baud,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      busy,
  output logic      tx_done
);

  localparam int               CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STP = 1'(STOP_BITS - 1);

  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 parity_acc;
  logic                 stop_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 tx_nxt;
  logic                 done_nxt;
  logic                 last_bit;
  logic                 last_stop;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.tx_valid),
    .pop   (pop),
    .din   (bus.tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.tx_ready = !fifo_full;
  assign last_bit     = (bit_cnt == LAST_BIT);
  assign last_stop    = (stop_cnt == LAST_STP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: the sequencer only moves on a baud strobe
  always_comb begin
    state_nxt = state;
    if (baud) begin
      case (state)
        IDLE:    if (!fifo_empty) state_nxt = START;
        START:   state_nxt = DATA;
        DATA:    if (last_bit) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  state_nxt = STOP;
        STOP:    if (last_stop) state_nxt = fifo_empty ? IDLE : START;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: next line level, FIFO pop and frame-done pulse
  always_comb begin
    pop      = 1'b0;
    tx_nxt   = tx;
    done_nxt = 1'b0;
    if (baud) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop    = 1'b1;
            tx_nxt = START_LEVEL;
          end
        end
        START:  tx_nxt = shift_reg[0];
        DATA: begin
          if (!last_bit)            tx_nxt = shift_reg[0];
          else if (PARITY_EN != 0)  tx_nxt = parity_acc ^ (PARITY_ODD != 0);
          else                      tx_nxt = UART_IDLE_LEVEL;
        end
        PARITY: tx_nxt = UART_IDLE_LEVEL;
        STOP: begin
          if (last_stop) begin
            done_nxt = 1'b1;
            // A queued byte starts immediately, with no idle bit in between
            if (!fifo_empty) begin
              pop    = 1'b1;
              tx_nxt = START_LEVEL;
            end else begin
              tx_nxt = UART_IDLE_LEVEL;
            end
          end
        end
        default: tx_nxt = UART_IDLE_LEVEL;
      endcase
    end
  end

  // Datapath: shift register, bit/stop counters, parity and output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      parity_acc <= 1'b0;
      stop_cnt   <= 1'b0;
      tx         <= UART_IDLE_LEVEL;
      tx_done    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tx      <= tx_nxt;
      tx_done <= done_nxt;
      busy    <= (state != IDLE) || !fifo_empty;
      if (pop) shift_reg <= fifo_dout;
      if (baud) begin
        case (state)
          START: begin
            shift_reg  <= shift_reg >> 1;
            bit_cnt    <= '0;
            parity_acc <= shift_reg[0];
          end
          DATA: begin
            if (!last_bit) begin
              shift_reg  <= shift_reg >> 1;
              bit_cnt    <= bit_cnt + 1'b1;
              parity_acc <= parity_acc ^ shift_reg[0];
            end else begin
              stop_cnt <= 1'b0;
            end
          end
          PARITY:  stop_cnt <= 1'b0;
          STOP:    stop_cnt <= last_stop ? 1'b0 : stop_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx: frame shape, back-to-back
//               frames, FIFO full behaviour, parity/two stop bits, reset
//               mid-frame and a random loopback through a frame decoder.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud = 1'b0;
  int   baud_div = 0;
  int   baud_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;

  uart_tx_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_if #(.DATA_BITS(8)) bus2 ();

  uart_tx #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .baud(baud), .bus(bus0), .tx(tx0), .busy(busy0), .tx_done(done0));
  uart_tx #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .baud(baud), .bus(bus1), .tx(tx1), .busy(busy1), .tx_done(done1));
  uart_tx #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud(baud), .bus(bus2), .tx(tx2), .busy(busy2), .tx_done(done2));

  always #5 clk = ~clk;

  // Baud strobe: one clk high every baud_div clks, off when baud_div is 0
  always @(negedge clk) begin
    if (baud_div <= 0) begin
      baud = 1'b0;
      baud_cnt = 0;
    end else begin
      baud_cnt++;
      if (baud_cnt >= baud_div) begin
        baud = 1'b1;
        baud_cnt = 0;
      end else begin
        baud = 1'b0;
      end
    end
  end

  // Reference receiver for dut0 (8N1) plus tx_done pulse counters
  logic [7:0] rxq[$];
  logic [7:0] rbyte;
  bit   in_frame = 0;
  bit   seen_frame = 0;
  int   rbit = 0;
  int   idle_run = 0;
  int   gap_total = 0;
  int   done_cnt0 = 0, done_cnt1 = 0, done_cnt2 = 0;
  logic prev_tx0 = 1'b1;
  logic mb, mr;

  always @(posedge clk) begin
    mb = baud;
    mr = rst;
    #1;
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (done2) done_cnt2++;
    if (tx0 !== prev_tx0) begin
      checks++;
      if (!mb && !mr) begin
        errors++;
        $display("FAIL glitch: tx went to %b on a clk without baud, required unchanged %b", tx0, prev_tx0);
      end
    end
    prev_tx0 = tx0;
    if (mr) begin
      in_frame = 0;
      idle_run = 0;
    end else if (mb) begin
      if (!in_frame) begin
        if (tx0 === 1'b0) begin
          in_frame = 1;
          rbit = 0;
          if (seen_frame) gap_total += idle_run;
          idle_run = 0;
        end else begin
          idle_run++;
        end
      end else if (rbit < 8) begin
        rbyte[rbit] = tx0;
        rbit++;
      end else begin
        checks++;
        if (tx0 !== 1'b1) begin
          errors++;
          $display("FAIL stop_bit: got %b, required 1", tx0);
        end
        rxq.push_back(rbyte);
        in_frame = 0;
        seen_frame = 1;
      end
    end
  end

  function automatic logic sel_busy(input int w);
    return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
  endfunction

  function automatic logic sel_tx(input int w);
    return (w == 0) ? tx0 : (w == 1) ? tx1 : tx2;
  endfunction

  task automatic wait_idle(input int w, input int max, output bit ok);
    ok = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sel_busy(w) === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_fall(input int w, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sel_tx(w) === 1'b0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic push0(input logic [7:0] d);
    @(negedge clk);
    bus0.tx_data = d;
    bus0.tx_valid = 1'b1;
    @(negedge clk);
    bus0.tx_valid = 1'b0;
    bus0.tx_data = 8'($urandom);
  endtask

  task automatic test_reset();
    baud_div = 16;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx0); end
    if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", bus0.tx_ready); end
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy0); end
    if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done0); end
    if (tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx1: got %b, required 1", tx1); end
    if (tx2 !== 1'b1) begin errors++; $display("FAIL reset_tx2: got %b, required 1", tx2); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // 0xA5 at 16 clk per bit, sampled mid-bit
  task automatic test_basic();
    logic [7:0] d;
    logic       exp_bits[10];
    int         d0;
    bit         ok;
    d = 8'hA5;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
    exp_bits[9] = 1'b1;
    rxq.delete();
    d0 = done_cnt0;
    baud_div = 16;
    push0(d);
    wait_fall(0, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_start: tx stayed %b, required fall within 40 clk", tx0); end
    repeat (7) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx0 !== exp_bits[i]) begin
        errors++;
        $display("FAIL basic_bit%0d: got %b, required %b", i, tx0, exp_bits[i]);
      end
      if (i < 9) repeat (16) @(negedge clk);
    end
    wait_idle(0, 100, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL basic_idle: busy=%b, required 0", busy0); end
    if (done_cnt0 - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses, required 1", done_cnt0 - d0); end
    if (rxq.size() != 1) begin errors++; $display("FAIL basic_rxcount: got %0d bytes, required 1", rxq.size()); end
    else if (rxq[0] !== d) begin errors++; $display("FAIL basic_rxbyte: got %h, required %h", rxq[0], d); end
    else if (tx0 !== 1'b1) begin errors++; $display("FAIL basic_idle_line: got %b, required 1", tx0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3];
    int         d0;
    bit         ok;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    rxq.delete();
    gap_total = 0;
    seen_frame = 0;
    d0 = done_cnt0;
    baud_div = 4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b, required 1", i, bus0.tx_ready); end
      bus0.tx_data = bytes[i];
      bus0.tx_valid = 1'b1;
    end
    @(negedge clk);
    bus0.tx_valid = 1'b0;
    wait_idle(0, 400, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL b2b_idle: busy=%b, required 0", busy0); end
    if (done_cnt0 - d0 != 3) begin errors++; $display("FAIL b2b_done: got %0d pulses, required 3", done_cnt0 - d0); end
    if (gap_total != 0) begin errors++; $display("FAIL b2b_gap: got %0d idle bits between frames, required 0", gap_total); end
    if (rxq.size() != 3) begin errors++; $display("FAIL b2b_rxcount: got %0d, required 3", rxq.size()); end
    for (int i = 0; i < 3 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== bytes[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h, required %h", i, rxq[i], bytes[i]); end
    end
  endtask

  // Six pushes with the serial side stalled: only FIFO_DEPTH fit
  task automatic test_fifo_full();
    logic [7:0] expq[$];
    logic [7:0] d;
    int         d0;
    bit         ok;
    rxq.delete();
    d0 = done_cnt0;
    baud_div = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d = 8'($urandom);
      checks++;
      if (bus0.tx_ready !== ((expq.size() < 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL full_ready%0d: got %b, required %b", i, bus0.tx_ready, (expq.size() < 4));
      end
      if (expq.size() < 4) expq.push_back(d);
      bus0.tx_data = d;
      bus0.tx_valid = 1'b1;
    end
    @(negedge clk);
    bus0.tx_valid = 1'b0;
    baud_div = 3;
    wait_idle(0, 600, ok);
    checks += 4;
    if (!ok) begin errors++; $display("FAIL full_idle: busy=%b, required 0", busy0); end
    if (done_cnt0 - d0 != 4) begin errors++; $display("FAIL full_done: got %0d pulses, required 4", done_cnt0 - d0); end
    if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL full_ready_end: got %b, required 1", bus0.tx_ready); end
    if (rxq.size() != 4) begin errors++; $display("FAIL full_rxcount: got %0d, required 4", rxq.size()); end
    for (int i = 0; i < 4 && i < rxq.size(); i++) begin
      checks++;
      if (rxq[i] !== expq[i]) begin errors++; $display("FAIL full_byte%0d: got %h, required %h", i, rxq[i], expq[i]); end
    end
  endtask

  // Even (dut1) and odd (dut2) parity with two stop bits, 8 clk per bit
  task automatic test_parity();
    logic [7:0] d;
    logic       e1[12];
    logic       e2[12];
    int         d1, d2;
    bit         ok;
    baud_div = 8;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 8'h07 : 8'($urandom);
      e1[0] = 1'b0;
      e2[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin e1[i+1] = d[i]; e2[i+1] = d[i]; end
      e1[9] = ($countones(d) % 2 == 1);
      e2[9] = ($countones(d) % 2 == 0);
      e1[10] = 1'b1; e1[11] = 1'b1;
      e2[10] = 1'b1; e2[11] = 1'b1;
      d1 = done_cnt1;
      d2 = done_cnt2;
      @(negedge clk);
      bus1.tx_data = d; bus1.tx_valid = 1'b1;
      bus2.tx_data = d; bus2.tx_valid = 1'b1;
      @(negedge clk);
      bus1.tx_valid = 1'b0;
      bus2.tx_valid = 1'b0;
      wait_fall(1, 30, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL par_start: tx stayed %b, required fall", tx1); end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
        checks += 2;
        if (tx1 !== e1[i]) begin errors++; $display("FAIL par_even_bit%0d byte %h: got %b, required %b", i, d, tx1, e1[i]); end
        if (tx2 !== e2[i]) begin errors++; $display("FAIL par_odd_bit%0d byte %h: got %b, required %b", i, d, tx2, e2[i]); end
        if (i < 11) repeat (8) @(negedge clk);
      end
      checks++;
      if (done_cnt1 != d1) begin errors++; $display("FAIL par_early_done: got %0d pulses in 2nd stop bit, required 0", done_cnt1 - d1); end
      wait_idle(1, 100, ok);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL par_idle: busy=%b, required 0", busy1); end
      if (done_cnt1 - d1 != 1) begin errors++; $display("FAIL par_done_even: got %0d, required 1", done_cnt1 - d1); end
      if (done_cnt2 - d2 != 1) begin errors++; $display("FAIL par_done_odd: got %0d, required 1", done_cnt2 - d2); end
    end
  endtask

  // Reset in the middle of the data bits, with a second byte queued
  task automatic test_reset_mid();
    logic [7:0] d;
    int         d0;
    bit         ok;
    baud_div = 8;
    rxq.delete();
    push0(8'($urandom));
    wait_fall(0, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmid_start: tx stayed %b, required fall", tx0); end
    push0(8'($urandom));
    repeat (8 * 5 + 1) @(negedge clk);
    d0 = done_cnt0;
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (tx0 !== 1'b1) begin errors++; $display("FAIL rmid_tx: got %b, required 1", tx0); end
    if (busy0 !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy0); end
    if (bus0.tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b, required 1", bus0.tx_ready); end
    if (done0 !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b, required 0", done0); end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checks += 3;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL rmid_fifo_flushed: busy=%b, required 0", busy0); end
    if (done_cnt0 != d0) begin errors++; $display("FAIL rmid_no_done: got %0d pulses, required 0", done_cnt0 - d0); end
    if (rxq.size() != 0) begin errors++; $display("FAIL rmid_no_byte: got %0d bytes, required 0", rxq.size()); end
    d = 8'($urandom);
    push0(d);
    wait_idle(0, 200, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL rmid_idle: busy=%b, required 0", busy0); end
    if (done_cnt0 - d0 != 1) begin errors++; $display("FAIL rmid_done_after: got %0d, required 1", done_cnt0 - d0); end
    if (rxq.size() != 1) begin errors++; $display("FAIL rmid_rxcount: got %0d, required 1", rxq.size()); end
    else begin
      checks++;
      if (rxq[0] !== d) begin errors++; $display("FAIL rmid_byte: got %h, required %h", rxq[0], d); end
    end
  endtask

  // Random bytes through the decoder at 1 and 2 clk per bit
  task automatic test_loopback();
    logic [7:0] expq[$];
    int         d0, sent;
    bit         ok;
    for (int pass = 0; pass < 2; pass++) begin
      baud_div = pass + 1;
      rxq.delete();
      expq.delete();
      d0 = done_cnt0;
      sent = 0;
      for (int cyc = 0; cyc < 20000 && sent < 100; cyc++) begin
        @(negedge clk);
        if (bus0.tx_ready === 1'b1 && $urandom_range(0, 3) != 0) begin
          bus0.tx_data = 8'($urandom);
          bus0.tx_valid = 1'b1;
          expq.push_back(bus0.tx_data);
          sent++;
        end else begin
          bus0.tx_valid = 1'b0;
        end
      end
      @(negedge clk);
      bus0.tx_valid = 1'b0;
      wait_idle(0, 3000, ok);
      checks += 4;
      if (sent != 100) begin errors++; $display("FAIL loop_sent: got %0d, required 100", sent); end
      if (!ok) begin errors++; $display("FAIL loop_idle: busy=%b, required 0", busy0); end
      if (done_cnt0 - d0 != sent) begin errors++; $display("FAIL loop_done: got %0d, required %0d", done_cnt0 - d0, sent); end
      if (rxq.size() != expq.size()) begin errors++; $display("FAIL loop_rxcount: got %0d, required %0d", rxq.size(), expq.size()); end
      for (int i = 0; i < rxq.size() && i < expq.size(); i++) begin
        checks++;
        if (rxq[i] !== expq[i]) begin errors++; $display("FAIL loop_byte%0d: got %h, required %h", i, rxq[i], expq[i]); end
      end
    end
  endtask

  initial begin
    bus0.tx_valid = 1'b0; bus0.tx_data = '0;
    bus1.tx_valid = 1'b0; bus1.tx_data = '0;
    bus2.tx_valid = 1'b0; bus2.tx_data = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_fifo_full();
    test_parity();
    test_reset_mid();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at 5 ms, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
